seq_detector: RTL and testbench
===============================

SEQ_DETECTOR -- requirements
Module: seq_detector

Interface
REQ-001 SHALL provide parameter PATTERN_LEN, default 4, meaning the number of pattern bits (legal range 2..16).
REQ-002 SHALL provide parameter CNT_WIDTH, default 8, meaning the width of the match counter.
REQ-003 SHALL provide parameter RST_PATTERN, default 4'b1011 (PATTERN_LEN bits), meaning the pattern held after reset.
REQ-004 SHALL have one clock and an asynchronous, active-high reset.
REQ-005 i_sys_clk  input  1  system clock; all state changes occur on its rising edge.
REQ-006 i_rst  input  1  asynchronous active-high reset.
REQ-007 i_data_in  input  1  serial data bit; sampled only when i_data_valid=1.
REQ-008 i_data_valid  input  1  qualifies i_data_in for the current cycle.
REQ-009 i_pattern  input  PATTERN_LEN  new pattern; bit [PATTERN_LEN-1] is the first expected bit.
REQ-010 i_load  input  1  latches i_pattern into the internal pattern register.
REQ-011 i_overlap_en  input  1  1=overlapping detection, 0=non-overlapping.
REQ-012 i_clr  input  1  synchronous clear of detector state and match counter.
REQ-013 o_moore_fsm_out  output  1  registered match flag.
REQ-014 o_mealy_fsm_out  output  1  combinational match flag.
REQ-015 o_match_cnt  output  CNT_WIDTH  number of matches since reset/clear.
REQ-016 o_cnt_sat  output  1  counter has reached all-ones.

Function
REQ-017 SHALL hold a state register S in 0..PATTERN_LEN = number of leading pattern bits currently matched.
REQ-018 On a valid bit, SHALL set next S = length of the longest pattern prefix that is a suffix of (matched prefix of length S' followed by i_data_in), where S'=S for S<PATTERN_LEN.
REQ-019 When S=PATTERN_LEN, S' SHALL be PATTERN_LEN-derived suffix (longest proper suffix-prefix) if i_overlap_en=1, and 0 if i_overlap_en=0.
REQ-020 When i_data_valid=0, S, counter and outputs derived from S SHALL hold.
REQ-021 o_moore_fsm_out SHALL equal (S==PATTERN_LEN): asserts one cycle after the edge sampling the last pattern bit, holds until the next valid bit.
REQ-022 o_mealy_fsm_out SHALL be 1 in the same cycle as a valid bit that will move S to PATTERN_LEN, and 0 whenever i_clr=1 or i_load=1.
REQ-023 o_match_cnt SHALL increment by 1 on each edge where o_mealy_fsm_out=1, saturating at 2^CNT_WIDTH-1 (no wrap).
REQ-024 o_cnt_sat SHALL be 1 exactly when o_match_cnt is all-ones.
REQ-025 i_load=1 SHALL latch i_pattern, force S=0 and discard the current bit; counter unchanged.
REQ-026 i_clr=1 SHALL force S=0 and o_match_cnt=0 and discard the current bit; pattern unchanged.
REQ-027 Priority SHALL be i_rst > i_clr > i_load > data; i_clr and i_load together perform both.
REQ-028 Changing i_overlap_en SHALL take effect on the next valid bit without clearing S.

Reset
REQ-029 While i_rst=1, SHALL force S=0, pattern=RST_PATTERN, o_match_cnt=0, o_moore_fsm_out=0, o_mealy_fsm_out=0, o_cnt_sat=0, independent of the clock.
REQ-030 Reset asserted mid-pattern SHALL discard all partial matches; detection restarts from the first valid bit after release.

Verification (PATTERN_LEN=4, pattern 1011 unless stated)
REQ-031 Reset: hold i_rst=1 for 10 cycles with toggling data -> all outputs 0; release -> outputs still 0.
REQ-032 Overlap: i_overlap_en=1, valid stream 1,0,1,1,0,1,1 -> Mealy pulses on bits 4 and 7, Moore one cycle later, o_match_cnt=2.
REQ-033 Non-overlap: i_overlap_en=0, same stream -> single Mealy pulse on bit 4, o_match_cnt=1.
REQ-034 Valid gaps: stream 1,0,1,1 with 3 invalid cycles (data toggling) between each bit -> exactly one match, Moore held high across trailing invalid cycles.
REQ-035 Saturation: CNT_WIDTH=2, five matches -> o_match_cnt=3, o_cnt_sat=1; i_clr coincident with a match -> o_match_cnt=0, S=0.
REQ-036 Load/reset mid-operation: after 1,0,1 assert i_load with i_pattern=0110 then send 1,1,0 -> no match; send 0,1,1,0 -> one match; assert i_rst after 0,1,1 -> no match on following 0.

Source files
------------

// File: rtl/seq_detector.sv
// Serial pattern detector with a run-time loadable pattern, overlapping or
// non-overlapping matching, Moore/Mealy match flags and a saturating match counter.
module seq_detector #(
  parameter int                     PATTERN_LEN = 4,
  parameter int                     CNT_WIDTH   = 8,
  parameter logic [PATTERN_LEN-1:0] RST_PATTERN = PATTERN_LEN'(4'b1011)
) (
  input  logic                   i_sys_clk,
  input  logic                   i_rst,
  input  logic                   i_data_in,
  input  logic                   i_data_valid,
  input  logic [PATTERN_LEN-1:0] i_pattern,
  input  logic                   i_load,
  input  logic                   i_overlap_en,
  input  logic                   i_clr,
  output logic                   o_moore_fsm_out,
  output logic                   o_mealy_fsm_out,
  output logic [CNT_WIDTH-1:0]   o_match_cnt,
  output logic                   o_cnt_sat
);

  localparam int SW = $clog2(PATTERN_LEN + 1);
  localparam int EW = PATTERN_LEN + 1;
  localparam logic [SW-1:0] FULL = SW'(PATTERN_LEN);

  logic [SW-1:0]          s_r;
  logic [PATTERN_LEN-1:0] pat_r;
  logic [CNT_WIDTH-1:0]   cnt_r;
  logic                   moore_r;
  logic                   sat_r;

  logic [SW-1:0]          border_s;
  logic [SW-1:0]          sp_s;
  logic [SW-1:0]          s_next_s;
  logic                   hit_s;
  logic [CNT_WIDTH-1:0]   cnt_inc_s;

  function automatic logic [EW-1:0] low_mask(input int unsigned k);
    return {EW{1'b1}} >> (EW - k);
  endfunction

  // Longest proper prefix of the pattern that is also a suffix of it.
  function automatic logic [SW-1:0] border_len(input logic [PATTERN_LEN-1:0] pat);
    logic [EW-1:0] p;
    logic [SW-1:0] best;
    p    = {1'b0, pat};
    best = '0;
    for (int unsigned k = 1; k < PATTERN_LEN; k++) begin
      if ((p >> (PATTERN_LEN - k)) == (p & low_mask(k))) best = SW'(k);
    end
    return best;
  endfunction

  // The first sp pattern bits followed by bit_in form a string of sp+1 bits;
  // the result is the longest pattern prefix that ends that string.
  function automatic logic [SW-1:0] advance(input logic [PATTERN_LEN-1:0] pat,
                                            input logic [SW-1:0] sp,
                                            input logic bit_in);
    logic [EW-1:0] p;
    logic [EW-1:0] str;
    logic [SW-1:0] best;
    p    = {1'b0, pat};
    str  = ((p >> (PATTERN_LEN - 32'(sp))) << 1) | EW'(bit_in);
    best = '0;
    for (int unsigned k = 1; k <= PATTERN_LEN; k++) begin
      if ((k <= 32'(sp) + 32'd1) && ((p >> (PATTERN_LEN - k)) == (str & low_mask(k))))
        best = SW'(k);
    end
    return best;
  endfunction

  // Next match length, Mealy flag and saturating counter increment.
  always_comb begin
    border_s = border_len(pat_r);
    if (s_r == FULL) begin
      if (i_overlap_en) sp_s = border_s;
      else              sp_s = '0;
    end else begin
      sp_s = s_r;
    end
    s_next_s = advance(pat_r, sp_s, i_data_in);
    hit_s    = i_data_valid && !i_clr && !i_load && !i_rst && (s_next_s == FULL);
    if (cnt_r == '1) cnt_inc_s = cnt_r;
    else             cnt_inc_s = cnt_r + CNT_WIDTH'(1);
  end

  // Detector state, pattern register, counter and registered flags.
  always_ff @(posedge i_sys_clk or posedge i_rst) begin
    if (i_rst) begin
      s_r     <= '0;
      pat_r   <= RST_PATTERN;
      cnt_r   <= '0;
      moore_r <= 1'b0;
      sat_r   <= 1'b0;
    end else if (i_clr || i_load) begin
      s_r     <= '0;
      moore_r <= 1'b0;
      if (i_clr) begin
        cnt_r <= '0;
        sat_r <= 1'b0;
      end
      if (i_load) pat_r <= i_pattern;
    end else if (i_data_valid) begin
      s_r     <= s_next_s;
      moore_r <= (s_next_s == FULL);
      if (hit_s) begin
        cnt_r <= cnt_inc_s;
        sat_r <= (cnt_inc_s == '1);
      end
    end
  end

  assign o_moore_fsm_out = moore_r;
  assign o_mealy_fsm_out = hit_s;
  assign o_match_cnt     = cnt_r;
  assign o_cnt_sat       = sat_r;

endmodule

// File: tb/tb_seq_detector.sv
// Self-checking bench for seq_detector: directed tables, hand sequences and a
// randomized run against a history-queue reference model.
module tb_seq_detector;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       data = 1'b0;
  logic       valid = 1'b0;
  logic [3:0] pattern = 4'b0000;
  logic       load = 1'b0;
  logic       ovl = 1'b1;
  logic       clr = 1'b0;

  logic       moore8, mealy8, sat8;
  logic [7:0] cnt8;
  logic       moore2, mealy2, sat2;
  logic [1:0] cnt2;

  int checks = 0;
  int errors = 0;
  int pulses = 0;

  // sampled DUT values of the most recent step
  logic       mealy_q, moore_q, sat_q, sat2_q;
  logic [7:0] cnt_q;
  logic [1:0] cnt2_q;

  // reference model: recent valid bits since last restart point
  bit         hq[$];
  bit         tq[$];
  logic [3:0] mpat;
  int         mcnt;
  bit         mmoore;

  typedef struct {
    logic d;
    logic v;
    logic exp_mealy;
    logic exp_moore;
    int   exp_cnt;
  } vec_t;

  vec_t ovl_tab[8];
  vec_t non_tab[8];

  seq_detector dut (
    .i_sys_clk(clk), .i_rst(rst), .i_data_in(data), .i_data_valid(valid),
    .i_pattern(pattern), .i_load(load), .i_overlap_en(ovl), .i_clr(clr),
    .o_moore_fsm_out(moore8), .o_mealy_fsm_out(mealy8),
    .o_match_cnt(cnt8), .o_cnt_sat(sat8)
  );

  seq_detector #(.CNT_WIDTH(2)) dut2 (
    .i_sys_clk(clk), .i_rst(rst), .i_data_in(data), .i_data_valid(valid),
    .i_pattern(pattern), .i_load(load), .i_overlap_en(ovl), .i_clr(clr),
    .o_moore_fsm_out(moore2), .o_mealy_fsm_out(mealy2),
    .o_match_cnt(cnt2), .o_cnt_sat(sat2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int min_i(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // One clock cycle: drive at posedge+1, compare at negedge, update model after posedge.
  task automatic step(input logic r, input logic c, input logic l, input logic v,
                      input logic d, input logic o, input logic [3:0] p);
    bit         em;
    logic [3:0] w;
    rst = r; clr = c; load = l; valid = v; data = d; ovl = o; pattern = p;
    if (r) begin
      hq = {}; mmoore = 1'b0; mcnt = 0; mpat = 4'b1011;
    end
    @(negedge clk);
    em = 1'b0;
    tq = hq;
    if (!r && !c && !l && v) begin
      if (mmoore && !o) tq = {};
      tq.push_back(d);
      if (tq.size() > 4) void'(tq.pop_front());
      w = 4'b0000;
      foreach (tq[i]) w = {w[2:0], tq[i]};
      em = (tq.size() == 4) && (w == mpat);
    end
    mealy_q = mealy8; moore_q = moore8; cnt_q = cnt8; sat_q = sat8;
    cnt2_q = cnt2; sat2_q = sat2;
    if (mealy8) pulses++;
    chk("mealy", int'(mealy8), int'(em));
    chk("mealy_w2", int'(mealy2), int'(em));
    chk("moore", int'(moore8), int'(mmoore));
    chk("moore_w2", int'(moore2), int'(mmoore));
    chk("cnt", int'(cnt8), min_i(mcnt, 255));
    chk("cnt_w2", int'(cnt2), min_i(mcnt, 3));
    chk("sat", int'(sat8), int'(mcnt >= 255));
    chk("sat_w2", int'(sat2), int'(mcnt >= 3));
    @(posedge clk);
    #1;
    if (!r) begin
      if (c) begin
        mcnt = 0; hq = {}; mmoore = 1'b0;
      end
      if (l) begin
        mpat = p; hq = {}; mmoore = 1'b0;
      end
      if (!c && !l && v) begin
        hq = tq; mmoore = em;
        if (em) mcnt++;
      end
    end
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0000);
  endtask

  task automatic send_bits(input logic [15:0] bits, input int n, input logic o);
    for (int i = 0; i < n; i++)
      step(1'b0, 1'b0, 1'b0, 1'b1, bits[n-1-i], o, 4'b0000);
  endtask

  task automatic idle(input logic o);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, o, 4'b0000);
  endtask

  initial begin
    logic [6:0] stream;
    stream = 7'b1011011;
    for (int i = 0; i < 7; i++) begin
      ovl_tab[i].d = stream[6-i]; ovl_tab[i].v = 1'b1;
      non_tab[i].d = stream[6-i]; non_tab[i].v = 1'b1;
    end
    ovl_tab[7].d = 1'b0; ovl_tab[7].v = 1'b0;
    non_tab[7].d = 1'b0; non_tab[7].v = 1'b0;
    // expected: mealy on bits 4 and 7 (overlap) / bit 4 only (non-overlap)
    ovl_tab[0].exp_mealy = 0; ovl_tab[0].exp_moore = 0; ovl_tab[0].exp_cnt = 0;
    ovl_tab[1].exp_mealy = 0; ovl_tab[1].exp_moore = 0; ovl_tab[1].exp_cnt = 0;
    ovl_tab[2].exp_mealy = 0; ovl_tab[2].exp_moore = 0; ovl_tab[2].exp_cnt = 0;
    ovl_tab[3].exp_mealy = 1; ovl_tab[3].exp_moore = 0; ovl_tab[3].exp_cnt = 0;
    ovl_tab[4].exp_mealy = 0; ovl_tab[4].exp_moore = 1; ovl_tab[4].exp_cnt = 1;
    ovl_tab[5].exp_mealy = 0; ovl_tab[5].exp_moore = 0; ovl_tab[5].exp_cnt = 1;
    ovl_tab[6].exp_mealy = 1; ovl_tab[6].exp_moore = 0; ovl_tab[6].exp_cnt = 1;
    ovl_tab[7].exp_mealy = 0; ovl_tab[7].exp_moore = 1; ovl_tab[7].exp_cnt = 2;
    non_tab[0].exp_mealy = 0; non_tab[0].exp_moore = 0; non_tab[0].exp_cnt = 0;
    non_tab[1].exp_mealy = 0; non_tab[1].exp_moore = 0; non_tab[1].exp_cnt = 0;
    non_tab[2].exp_mealy = 0; non_tab[2].exp_moore = 0; non_tab[2].exp_cnt = 0;
    non_tab[3].exp_mealy = 1; non_tab[3].exp_moore = 0; non_tab[3].exp_cnt = 0;
    non_tab[4].exp_mealy = 0; non_tab[4].exp_moore = 1; non_tab[4].exp_cnt = 1;
    non_tab[5].exp_mealy = 0; non_tab[5].exp_moore = 0; non_tab[5].exp_cnt = 1;
    non_tab[6].exp_mealy = 0; non_tab[6].exp_moore = 0; non_tab[6].exp_cnt = 1;
    non_tab[7].exp_mealy = 0; non_tab[7].exp_moore = 0; non_tab[7].exp_cnt = 1;

    mpat = 4'b1011; mcnt = 0; mmoore = 1'b0;
    @(posedge clk);
    #1;

    // reset held for 10 cycles with toggling data, then released
    for (int i = 0; i < 10; i++)
      step(1'b1, 1'b0, 1'b0, 1'b1, i[0], 1'b1, 4'b0000);
    idle(1'b1);
    chk("rst_release_moore", int'(moore_q), 0);
    chk("rst_release_cnt", int'(cnt_q), 0);

    // overlapping table
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b0, 1'b0, ovl_tab[i].v, ovl_tab[i].d, 1'b1, 4'b0000);
      chk("tab_ovl_mealy", int'(mealy_q), int'(ovl_tab[i].exp_mealy));
      chk("tab_ovl_moore", int'(moore_q), int'(ovl_tab[i].exp_moore));
      chk("tab_ovl_cnt", int'(cnt_q), ovl_tab[i].exp_cnt);
    end

    // non-overlapping table
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b0, 1'b0, non_tab[i].v, non_tab[i].d, 1'b0, 4'b0000);
      chk("tab_non_mealy", int'(mealy_q), int'(non_tab[i].exp_mealy));
      chk("tab_non_moore", int'(moore_q), int'(non_tab[i].exp_moore));
      chk("tab_non_cnt", int'(cnt_q), non_tab[i].exp_cnt);
    end

    // valid gaps: 1,0,1,1 with 3 invalid toggling cycles after each bit
    do_reset();
    pulses = 0;
    for (int b = 0; b < 4; b++) begin
      step(1'b0, 1'b0, 1'b0, 1'b1, (b == 1) ? 1'b0 : 1'b1, 1'b1, 4'b0000);
      for (int g = 0; g < 3; g++) begin
        step(1'b0, 1'b0, 1'b0, 1'b0, g[0], 1'b1, 4'b0000);
        if (b == 3) chk("gap_moore_hold", int'(moore_q), 1);
      end
    end
    chk("gap_pulses", pulses, 1);
    chk("gap_cnt", int'(cnt_q), 1);

    // saturation of the 2-bit counter after five overlapping matches
    do_reset();
    send_bits(16'b1011011011011011, 16, 1'b1);
    idle(1'b1);
    chk("sat_cnt_w2", int'(cnt2_q), 3);
    chk("sat_flag_w2", int'(sat2_q), 1);
    chk("sat_cnt_w8", int'(cnt_q), 5);
    send_bits(16'b0000000000000101, 3, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 4'b0000);
    chk("clr_match_mealy", int'(mealy_q), 0);
    idle(1'b1);
    chk("clr_cnt_w2", int'(cnt2_q), 0);
    chk("clr_sat_w2", int'(sat2_q), 0);
    pulses = 0;
    send_bits(16'b0000000000000011, 3, 1'b1);
    chk("clr_state_zero", pulses, 0);

    // load mid-pattern, then reset mid-pattern
    do_reset();
    send_bits(16'b0000000000000101, 3, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'b0110);
    chk("load_mealy", int'(mealy_q), 0);
    pulses = 0;
    send_bits(16'b0000000000000110, 3, 1'b1);
    chk("load_no_match", pulses, 0);
    send_bits(16'b0000000000000110, 4, 1'b1);
    chk("load_one_match", pulses, 1);
    send_bits(16'b0000000000000011, 3, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000);
    pulses = 0;
    send_bits(16'b0000000000000000, 1, 1'b1);
    chk("rst_mid_no_match", pulses, 0);

    // randomized run against the reference model
    for (int i = 0; i < 3000; i++) begin
      logic r, c, l, v, d, o;
      logic [3:0] p;
      r = ($urandom_range(0, 299) == 0);
      c = ($urandom_range(0, 59) == 0);
      l = ($urandom_range(0, 39) == 0);
      v = ($urandom_range(0, 3) != 0);
      d = 1'($urandom_range(0, 1));
      o = (($urandom_range(0, 15) == 0) ? ~ovl : ovl);
      p = 4'($urandom_range(0, 15));
      step(r, c, l, v, d, o, p);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
